// File: rtl/register_sync_loader_if.sv
// register_sync_loader_if: load request/status and dual write-port handshake bundle.
interface register_sync_loader_if #(
   parameter int REGISTER_AMOUNT = 32,
   parameter int REGISTER_WIDTH  = 64,
   parameter int REG_CTN_WIDTH   = $clog2(REGISTER_AMOUNT)
);
   logic                      load_start;
   logic                      load_target;
   logic                      load_busy;
   logic                      load_done;
   logic                      wr_valid_1;
   logic                      wr_ready_1;
   logic                      wr_valid_2;
   logic                      wr_ready_2;
   logic [REG_CTN_WIDTH-1:0]  wr_addr;
   logic [REGISTER_WIDTH-1:0] wr_data;
   modport master (
      input  load_start, load_target, wr_ready_1, wr_ready_2,
      output load_busy, load_done, wr_valid_1, wr_valid_2, wr_addr, wr_data
   );
   modport slave (
      output load_start, load_target, wr_ready_1, wr_ready_2,
      input  load_busy, load_done, wr_valid_1, wr_valid_2, wr_addr, wr_data
   );
endinterface

// File: rtl/register_sync_loader.sv
// register_sync_loader: streams registers 1..N-1 of the merged set into one processor's write port.
module register_sync_loader #(
   parameter int REGISTER_AMOUNT = 32,
   parameter int REGISTER_WIDTH  = 64,
   parameter int REG_CTN_WIDTH   = $clog2(REGISTER_AMOUNT)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [REGISTER_WIDTH-1:0] registers_renew [0:REGISTER_AMOUNT-1],
   register_sync_loader_if.master    bus
);
   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
   localparam logic [REG_CTN_WIDTH-1:0] LAST = REG_CTN_WIDTH'(REGISTER_AMOUNT - 1);
   state_t                   state, state_n;
   logic [REG_CTN_WIDTH-1:0] idx, idx_n, addr;
   logic                     target, target_n, hs;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         idx    <= '0;
         target <= 1'b0;
      end else begin
         state  <= state_n;
         idx    <= idx_n;
         target <= target_n;
      end
   end
   // Ready of the unselected port, or any ready outside LOAD, never counts.
   always_comb begin
      state_n         = state;
      idx_n           = idx;
      target_n        = target;
      hs              = (state == LOAD) && (target ? bus.wr_ready_2 : bus.wr_ready_1);
      addr            = (state == LOAD) ? idx : '0;
      bus.load_busy   = state != IDLE;
      bus.load_done   = state == DONE;
      bus.wr_valid_1  = (state == LOAD) && !target;
      bus.wr_valid_2  = (state == LOAD) && target;
      bus.wr_addr     = addr;
      if (state == IDLE && bus.load_start) begin
         state_n  = LOAD;
         idx_n    = REG_CTN_WIDTH'(1);
         target_n = bus.load_target;
      end else if (hs) begin
         state_n = (idx == LAST) ? DONE : LOAD;
         idx_n   = (idx == LAST) ? idx : idx + REG_CTN_WIDTH'(1);
      end else if (state == DONE) begin
         state_n = IDLE;
      end
   end
   assign bus.wr_data = registers_renew[addr];
endmodule

// File: tb/tb_register_sync_loader.sv
// tb_register_sync_loader: table-driven loads checked by an address/data scoreboard.
module tb_register_sync_loader;
   localparam int N = 32;
   localparam logic [63:0] BASE = 64'hA000_0000_0000_0000;
   localparam logic [63:0] LIVE = 64'h5555_0000_0000_0000;
   typedef struct {
      logic tgt;
      int   gap;
      int   stall_at;
      int   stall_len;
      int   ign_at;
      bit   live;
      int   exp_cycles;
   } vec_t;
   typedef struct {
      logic [4:0]  addr;
      logic [63:0] data;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] regs [0:N-1];
   int          total = 0;
   int          bad = 0;
   exp_t        q[$];
   logic        cur_tgt = 1'b0;
   logic        pend = 1'b0;
   logic [4:0]  pend_addr;
   logic        vs, rs, vo;
   exp_t        e;
   vec_t        vecs [7];

   register_sync_loader_if #(.REGISTER_AMOUNT(N), .REGISTER_WIDTH(64)) bus ();
   register_sync_loader #(.REGISTER_AMOUNT(N), .REGISTER_WIDTH(64)) dut (
      .clk(clk), .rst_n(rst_n), .registers_renew(regs), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Sampled mid-cycle: a valid&ready seen here is the handshake at the next edge.
   always @(negedge clk) begin
      if (rst_n) begin
         vs = cur_tgt ? bus.wr_valid_2 : bus.wr_valid_1;
         rs = cur_tgt ? bus.wr_ready_2 : bus.wr_ready_1;
         vo = cur_tgt ? bus.wr_valid_1 : bus.wr_valid_2;
         if (bus.load_busy) chk("other_valid", 64'(vo), 64'd0);
         if (pend) begin
            chk("stall_valid", 64'(vs), 64'd1);
            chk("stall_addr", 64'(bus.wr_addr), 64'(pend_addr));
         end
         if (vs && rs) begin
            if (q.size() == 0) chk("unexpected_write", 64'(bus.wr_addr), 64'd0);
            else begin
               e = q.pop_front();
               chk("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
               chk("wr_data", bus.wr_data, e.data);
            end
         end
         pend      = vs && !rs;
         pend_addr = bus.wr_addr;
      end
   end

   task automatic push_load(input vec_t v);
      for (int i = 1; i < N; i++) begin
         exp_t x;
         x.addr = 5'(i);
         x.data = (v.live && i == v.stall_at) ? LIVE + 64'(i) : BASE + 64'(i);
         q.push_back(x);
      end
   endtask

   task automatic run_load(input vec_t v);
      int  cyc;
      int  stalls;
      bit  ign_done;
      for (int g = 0; g < v.gap; g++) begin
         chk("idle_busy", 64'(bus.load_busy), 64'd0);
         @(posedge clk); #1;
      end
      cur_tgt = v.tgt;
      push_load(v);
      bus.load_start  = 1'b1;
      bus.load_target = v.tgt;
      @(posedge clk); #1;
      bus.load_start = 1'b0;
      chk("busy_after_start", 64'(bus.load_busy), 64'd1);
      cyc = 1;
      stalls = 0;
      ign_done = 0;
      while (!bus.load_done && cyc < 300) begin
         bus.load_start = 1'b0;
         if (v.ign_at != 0 && int'(bus.wr_addr) == v.ign_at && !ign_done) begin
            bus.load_start  = 1'b1;
            bus.load_target = !v.tgt;
            ign_done = 1;
         end
         if (int'(bus.wr_addr) == v.stall_at && stalls < v.stall_len) begin
            stalls++;
            if (v.live && stalls == v.stall_len) regs[v.stall_at] = LIVE + 64'(v.stall_at);
            if (v.tgt) bus.wr_ready_2 = 1'b0; else bus.wr_ready_1 = 1'b0;
         end else begin
            bus.wr_ready_1 = 1'b1;
            bus.wr_ready_2 = 1'b1;
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus.load_start = 1'b0;
      bus.wr_ready_1 = 1'b1;
      bus.wr_ready_2 = 1'b1;
      chk("done_cycle", 64'(cyc), 64'(v.exp_cycles));
      chk("done_busy", 64'(bus.load_busy), 64'd1);
      chk("done_valid", 64'({bus.wr_valid_1, bus.wr_valid_2}), 64'd0);
      chk("writes_left", 64'(q.size()), 64'd0);
      if (v.ign_at != 0) chk("ign_seen", 64'(ign_done), 64'd1);
      @(posedge clk); #1;
      chk("done_pulse_len", 64'(bus.load_done), 64'd0);
      chk("busy_fall", 64'(bus.load_busy), 64'd0);
      if (v.live) regs[v.stall_at] = BASE + 64'(v.stall_at);
   endtask

   initial begin
      vec_t rv;
      int   w;
      //            tgt gap stall len ign live exp
      vecs[0] = '{1'b0, 2, 0,  0, 0,  0, 32};
      vecs[1] = '{1'b1, 2, 5,  3, 0,  0, 35};
      vecs[2] = '{1'b1, 2, 0,  0, 12, 0, 32};
      vecs[3] = '{1'b0, 0, 0,  0, 0,  0, 32};
      vecs[4] = '{1'b1, 2, 20, 3, 0,  1, 35};
      vecs[5] = '{1'b0, 0, 31, 2, 0,  0, 34};
      vecs[6] = '{1'b0, 1, 1,  1, 0,  0, 33};
      for (int i = 0; i < N; i++) regs[i] = BASE + 64'(i);
      bus.load_start  = 1'b0;
      bus.load_target = 1'b0;
      bus.wr_ready_1  = 1'b1;
      bus.wr_ready_2  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(bus.load_busy), 64'd0);
      chk("rst_done", 64'(bus.load_done), 64'd0);
      chk("rst_valid", 64'({bus.wr_valid_1, bus.wr_valid_2}), 64'd0);
      chk("rst_addr", 64'(bus.wr_addr), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      rv = '{1'b0, 0, 0, 0, 0, 0, 32};
      cur_tgt = 1'b0;
      push_load(rv);
      bus.load_start = 1'b1;
      @(posedge clk); #1;
      bus.load_start = 1'b0;
      w = 0;
      while (bus.wr_addr != 5'd7 && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      chk("reached_addr7", 64'(bus.wr_addr), 64'd7);
      rst_n = 1'b0;
      #1;
      chk("async_busy", 64'(bus.load_busy), 64'd0);
      chk("async_done", 64'(bus.load_done), 64'd0);
      chk("async_valid", 64'({bus.wr_valid_1, bus.wr_valid_2}), 64'd0);
      chk("async_addr", 64'(bus.wr_addr), 64'd0);
      q.delete();
      pend = 1'b0;
      @(posedge clk); #1;
      chk("held_in_reset", 64'(bus.load_busy), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      foreach (vecs[i]) run_load(vecs[i]);
      repeat (3) begin
         chk("final_idle", 64'(bus.load_busy), 64'd0);
         @(posedge clk); #1;
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
